// File: rtl/mips_mem_pkg.sv
// Shared opcodes, FSM state type and opcode classification helpers for the
// MIPS memory-access stage.
package mips_mem_pkg;

   localparam int unsigned OPCODE_W = 6;

   localparam logic [OPCODE_W-1:0] OP_LB  = 6'h20;
   localparam logic [OPCODE_W-1:0] OP_LH  = 6'h21;
   localparam logic [OPCODE_W-1:0] OP_LWL = 6'h22;
   localparam logic [OPCODE_W-1:0] OP_LW  = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_LBU = 6'h24;
   localparam logic [OPCODE_W-1:0] OP_LHU = 6'h25;
   localparam logic [OPCODE_W-1:0] OP_LWR = 6'h26;
   localparam logic [OPCODE_W-1:0] OP_SB  = 6'h28;
   localparam logic [OPCODE_W-1:0] OP_SH  = 6'h29;
   localparam logic [OPCODE_W-1:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   function automatic logic is_load(input logic [OPCODE_W-1:0] opcode);
      return (opcode == OP_LB)  || (opcode == OP_LH)  || (opcode == OP_LWL) ||
             (opcode == OP_LW)  || (opcode == OP_LBU) || (opcode == OP_LHU) ||
             (opcode == OP_LWR);
   endfunction

   function automatic logic is_store(input logic [OPCODE_W-1:0] opcode);
      return (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
   endfunction

   // Halfwords may not straddle the word; whole words must be word aligned.
   function automatic logic is_misaligned(input logic [OPCODE_W-1:0] opcode,
                                          input logic [1:0]          offset);
      logic half, word;
      half = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
      word = (opcode == OP_LW) || (opcode == OP_SW);
      return (half && (offset == 2'd3)) || (word && (offset != 2'd0));
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data aligner: extracts, extends or merges the bus word
// into a register-ready value according to the load opcode and byte offset.
module load_aligner
   import mips_mem_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [1:0]          byte_offset,
   input  logic [31:0]         readdata,
   input  logic [31:0]         rt_old,
   output logic [31:0]         result
);

   logic [4:0]  low_sh;
   logic [4:0]  lwl_sh;
   logic [31:0] shifted;

   always_comb begin
      low_sh  = 5'({byte_offset, 3'b000});
      lwl_sh  = 5'({~byte_offset, 3'b000});
      shifted = readdata >> low_sh;
      result  = readdata;
      unique case (opcode)
         OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  result = {24'h0, shifted[7:0]};
         OP_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  result = {16'h0, shifted[15:0]};
         OP_LWL:  result = (readdata << lwl_sh) | (rt_old & ~(32'hFFFF_FFFF << lwl_sh));
         OP_LWR:  result = shifted | (rt_old & ~(32'hFFFF_FFFF >> low_sh));
         default: result = readdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one Avalon-MM read/write per load/store with aligned load results.
// Optional macro MEM_ALIGN_CHECK_EN suppresses misaligned accesses and flags addr_error.
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       instruction,
   input  logic [ADDR_W-1:0] address,
   input  logic [1:0]        byte_offset,
   input  logic [3:0]        byteenable,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] rt_old,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] load_result,
   output logic              addr_error,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest
);

   state_t state_q, state_d;

   logic [OPCODE_W-1:0] opcode_in;
   logic [OPCODE_W-1:0] opcode_q;
   logic [1:0]          offset_q;
   logic [DATA_W-1:0]   rt_old_q;
   logic                accept;
   logic                misaligned;
   logic [DATA_W-1:0]   lane_data;
   logic [DATA_W-1:0]   aligned;
   logic [25:0]         unused_instr;

   assign opcode_in    = instruction[31:26];
   assign unused_instr = instruction[25:0];

   // Next state, start acceptance and lane-replicated store data
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      misaligned = 1'b0;
      lane_data  = store_data;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned = is_misaligned(opcode_in, byte_offset);
`endif
      unique case (opcode_in)
         OP_SB:   lane_data = {4{store_data[7:0]}};
         OP_SH:   lane_data = {2{store_data[15:0]}};
         default: lane_data = store_data;
      endcase
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (misaligned)               state_d = DONE;
               else if (is_load(opcode_in))  state_d = READ;
               else if (is_store(opcode_in)) state_d = WRITE;
               else                          state_d = DONE;
            end
         end
         READ:    if (!avm_waitrequest) state_d = DONE;
         WRITE:   if (!avm_waitrequest) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   load_aligner u_load_aligner (
      .opcode      (opcode_q),
      .byte_offset (offset_q),
      .readdata    (avm_readdata),
      .rt_old      (rt_old_q),
      .result      (aligned)
   );

   // State register and registered outputs decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         opcode_q       <= '0;
         offset_q       <= '0;
         rt_old_q       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         load_result    <= '0;
         addr_error     <= 1'b0;
         avm_address    <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
      end else begin
         state_q    <= state_d;
         busy       <= (state_d == READ) || (state_d == WRITE);
         done       <= (state_d == DONE);
         avm_read   <= (state_d == READ);
         avm_write  <= (state_d == WRITE);
         addr_error <= accept && misaligned;
         if (accept) begin
            opcode_q       <= opcode_in;
            offset_q       <= byte_offset;
            rt_old_q       <= rt_old;
            avm_address    <= address;
            avm_byteenable <= byteenable;
            avm_writedata  <= lane_data;
         end
         if ((state_q == READ) && !avm_waitrequest)
            load_result <= aligned;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; honours MEM_ALIGN_CHECK_EN.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] instruction;
   logic [31:0] address;
   logic [1:0]  byte_offset;
   logic [3:0]  byteenable;
   logic [31:0] store_data;
   logic [31:0] rt_old;
   logic        busy;
   logic        done;
   logic [31:0] load_result;
   logic        addr_error;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   int checks   = 0;
   int failures = 0;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .instruction     (instruction),
      .address         (address),
      .byte_offset     (byte_offset),
      .byteenable      (byteenable),
      .store_data      (store_data),
      .rt_old          (rt_old),
      .busy            (busy),
      .done            (done),
      .load_result     (load_result),
      .addr_error      (addr_error),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   // Present one start pulse; returns 1 ns after the accepting edge.
   task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [1:0] k,
                        input logic [3:0] be, input logic [31:0] rt, input logic [31:0] old);
      instruction = {op, 26'h0}; address = addr; byte_offset = k;
      byteenable = be; store_data = rt; rt_old = old; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, addr_error, avm_read, avm_write} !== 5'b0 || load_result !== 32'h0 ||
          avm_address !== 32'h0 || avm_writedata !== 32'h0 || avm_byteenable !== 4'h0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b lr=%h addr=%h wd=%h be=%h, want all zero",
                  busy, done, load_result, avm_address, avm_writedata, avm_byteenable);
      end
   endtask

   // LB then LBU at k=1, no wait states
   task automatic test_byte_loads();
      avm_waitrequest = 1'b0; avm_readdata = 32'h1234_80FF;
      issue(6'h20, 32'h0000_1000, 2'd1, 4'b0010, 32'h0, 32'h0);
      checks++;
      if (avm_read !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL lb_bus_cycle: read=%b busy=%b done=%b, want 1 1 0", avm_read, busy, done);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || avm_read !== 1'b0 || busy !== 1'b0 || load_result !== 32'hFFFF_FF80) begin
         failures++;
         $display("FAIL lb_done: done=%b read=%b busy=%b lr=%h, want 1 0 0 ffffff80",
                  done, avm_read, busy, load_result);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL lb_done_pulse: done=%b, want 0", done);
      end
      issue(6'h24, 32'h0000_1000, 2'd1, 4'b0010, 32'h0, 32'h0);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || load_result !== 32'h0000_0080) begin
         failures++;
         $display("FAIL lbu_result: done=%b lr=%h, want 1 00000080", done, load_result);
      end
      @(posedge clk); #1;
   endtask

   // LH at k=2 with waitrequest held for three cycles
   task automatic test_halfword_wait();
      avm_waitrequest = 1'b1; avm_readdata = 32'h8001_0000;
      issue(6'h21, 32'h0000_2000, 2'd2, 4'b1100, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (avm_read !== 1'b1 || avm_address !== 32'h0000_2000 || avm_byteenable !== 4'b1100 ||
             done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL lh_stall_%0d: read=%b addr=%h be=%b done=%b busy=%b, want 1 00002000 1100 0 1",
                     i, avm_read, avm_address, avm_byteenable, done, busy);
         end
         if (i == 3) avm_waitrequest = 1'b0;
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || avm_read !== 1'b0 || load_result !== 32'hFFFF_8001) begin
         failures++;
         $display("FAIL lh_result: done=%b read=%b lr=%h, want 1 0 ffff8001", done, avm_read, load_result);
      end
      @(posedge clk); #1;
   endtask

   // LWL k=1 and LWR k=2 merges with rt_old
   task automatic test_merge_loads();
      avm_waitrequest = 1'b0; avm_readdata = 32'hAABB_CCDD;
      issue(6'h22, 32'h0000_3000, 2'd1, 4'b1111, 32'h0, 32'h1122_3344);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || load_result !== 32'hCCDD_3344) begin
         failures++;
         $display("FAIL lwl_result: done=%b lr=%h, want 1 ccdd3344", done, load_result);
      end
      @(posedge clk); #1;
      issue(6'h26, 32'h0000_3000, 2'd2, 4'b1111, 32'h0, 32'h1122_3344);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || load_result !== 32'h1122_AABB) begin
         failures++;
         $display("FAIL lwr_result: done=%b lr=%h, want 1 1122aabb", done, load_result);
      end
      @(posedge clk); #1;
   endtask

   // SB with a second start while busy and another during DONE
   task automatic test_store_byte();
      int dones = 0;
      avm_waitrequest = 1'b0; avm_readdata = 32'h5555_5555;
      issue(6'h28, 32'h0000_4000, 2'd2, 4'b0100, 32'h0000_00A5, 32'h0);
      checks++;
      if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_writedata !== 32'hA5A5_A5A5 ||
          avm_byteenable !== 4'b0100 || avm_address !== 32'h0000_4000) begin
         failures++;
         $display("FAIL sb_bus: write=%b read=%b wd=%h be=%b addr=%h, want 1 0 a5a5a5a5 0100 00004000",
                  avm_write, avm_read, avm_writedata, avm_byteenable, avm_address);
      end
      instruction = {6'h23, 26'h0}; address = 32'h0000_5000; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
         if (i == 1) start = 1'b0;
         checks++;
         if (avm_read !== 1'b0 || (i > 0 && avm_write !== 1'b0)) begin
            failures++;
            $display("FAIL sb_ignore_start_%0d: read=%b write=%b, want 0 0", i, avm_read, avm_write);
         end
      end
      checks++;
      if (dones != 1 || load_result !== 32'h1122_AABB) begin
         failures++;
         $display("FAIL sb_single_done: dones=%0d lr=%h, want 1 1122aabb", dones, load_result);
      end
   endtask

   // Asynchronous reset during a stalled read, then a clean LW
   task automatic test_reset_mid_read();
      avm_waitrequest = 1'b1; avm_readdata = 32'hDEAD_BEEF;
      issue(6'h23, 32'h0000_6000, 2'd0, 4'b1111, 32'h0, 32'h0);
      @(posedge clk); #2;
      reset = 1'b1; #1;
      checks++;
      if (avm_read !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_result !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: read=%b busy=%b done=%b lr=%h, want 0 0 0 00000000",
                  avm_read, busy, done, load_result);
      end
      @(negedge clk); reset = 1'b0; avm_waitrequest = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || avm_read !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle_%0d: done=%b read=%b, want 0 0", i, done, avm_read);
         end
      end
      issue(6'h23, 32'h0000_6000, 2'd0, 4'b1111, 32'h0, 32'h0);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || load_result !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL post_reset_lw: done=%b lr=%h, want 1 deadbeef", done, load_result);
      end
      @(posedge clk); #1;
   endtask

   // Non-memory opcode: DONE after one cycle with no bus activity
   task automatic test_non_memory();
      issue(6'h00, 32'h0000_7000, 2'd0, 4'b1111, 32'h0, 32'h0);
      checks++;
      if (done !== 1'b1 || avm_read !== 1'b0 || avm_write !== 1'b0 || busy !== 1'b0 ||
          load_result !== 32'hDEAD_BEEF || addr_error !== 1'b0) begin
         failures++;
         $display("FAIL non_memory: done=%b read=%b write=%b busy=%b lr=%h err=%b, want 1 0 0 0 deadbeef 0",
                  done, avm_read, avm_write, busy, load_result, addr_error);
      end
      @(posedge clk); #1;
   endtask

   // LW at k=2: suppressed with addr_error when checking is enabled
   task automatic test_misaligned_lw();
      avm_waitrequest = 1'b0; avm_readdata = 32'h0BAD_F00D;
      issue(6'h23, 32'h0000_8000, 2'd2, 4'b1111, 32'h0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      checks++;
      if (avm_read !== 1'b0 || done !== 1'b1 || addr_error !== 1'b1 || load_result !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL misaligned_lw: read=%b done=%b err=%b lr=%h, want 0 1 1 deadbeef",
                  avm_read, done, addr_error, load_result);
      end
      @(posedge clk); #1;
      checks++;
      if (addr_error !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL misaligned_clear: err=%b done=%b, want 0 0", addr_error, done);
      end
`else
      checks++;
      if (avm_read !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL misaligned_lw_bus: read=%b done=%b, want 1 0", avm_read, done);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || addr_error !== 1'b0 || load_result !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL misaligned_lw_result: done=%b err=%b lr=%h, want 1 0 0badf00d",
                  done, addr_error, load_result);
      end
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instruction = '0; address = '0; byte_offset = '0;
      byteenable = '0; store_data = '0; rt_old = '0; avm_readdata = '0; avm_waitrequest = 1'b0;
      #12;
      test_reset();
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      test_byte_loads();
      test_halfword_wait();
      test_merge_loads();
      test_store_byte();
      test_reset_mid_read();
      test_non_memory();
      test_misaligned_lw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
